// File: rtl/soc_periph_arbiter_if.sv
// Request/response bundle between the bus masters, the peripheral arbiter and its targets.
// The arbiter connects through the slave modport. The master modport is the view of the
// environment that drives requests and models the targets.
interface soc_periph_arbiter_if #(
    parameter int unsigned NrMasters = 2,
    parameter int unsigned NrTargets = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
);
    // Master side
    logic [NrMasters-1:0]                m_req_valid_i;
    logic [NrMasters-1:0]                m_req_ready_o;
    logic [NrMasters-1:0][AddrWidth-1:0] m_req_addr_i;
    logic [NrMasters-1:0]                m_req_we_i;
    logic [NrMasters-1:0][DataWidth-1:0] m_req_wdata_i;
    logic [NrMasters-1:0]                m_rsp_valid_o;
    logic [NrMasters-1:0]                m_rsp_ready_i;
    logic [DataWidth-1:0]                m_rsp_rdata_o;
    logic                                m_rsp_err_o;

    // Target side
    logic [NrTargets-1:0]                s_req_valid_o;
    logic [NrTargets-1:0]                s_req_ready_i;
    logic [AddrWidth-1:0]                s_req_addr_o;
    logic                                s_req_we_o;
    logic [DataWidth-1:0]                s_req_wdata_o;
    logic [NrTargets-1:0]                s_rsp_valid_i;
    logic [NrTargets-1:0][DataWidth-1:0] s_rsp_rdata_i;
    logic [NrTargets-1:0]                s_rsp_err_i;

    modport slave (
        input  m_req_valid_i, m_req_addr_i, m_req_we_i, m_req_wdata_i, m_rsp_ready_i,
        input  s_req_ready_i, s_rsp_valid_i, s_rsp_rdata_i, s_rsp_err_i,
        output m_req_ready_o, m_rsp_valid_o, m_rsp_rdata_o, m_rsp_err_o,
        output s_req_valid_o, s_req_addr_o, s_req_we_o, s_req_wdata_o
    );

    modport master (
        output m_req_valid_i, m_req_addr_i, m_req_we_i, m_req_wdata_i, m_rsp_ready_i,
        output s_req_ready_i, s_rsp_valid_i, s_rsp_rdata_i, s_rsp_err_i,
        input  m_req_ready_o, m_rsp_valid_o, m_rsp_rdata_o, m_rsp_err_o,
        input  s_req_valid_o, s_req_addr_o, s_req_we_o, s_req_wdata_o
    );
endinterface

// File: rtl/soc_periph_arbiter.sv
// Round-robin arbiter that shares the SoC peripheral space between the bus masters.
// It runs one transaction at a time and decodes the address to DRAM, ZYNQ, CLINT or Debug.
// It answers with an error for unmapped addresses and for targets that stop responding.
// The target indices of the address map are fixed, so NrTargets must be 4.
module soc_periph_arbiter #(
    parameter int unsigned NrMasters     = 2,
    parameter int unsigned NrTargets     = 4,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64
) (
    input logic                  clk_i,
    input logic                  rst_i,
    soc_periph_arbiter_if.slave  bus
);

    localparam int unsigned IdW  = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int unsigned IdxW = (NrTargets > 1) ? $clog2(NrTargets) : 1;
    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic [IdW-1:0]       id_q, id_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 win_found;
    logic [IdW-1:0]       win;
    logic [63:0]          win_addr;
    logic                 dec_hit;
    logic [IdxW-1:0]      dec_idx;
    logic                 timeout;

    // Pick the first requesting master at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            int unsigned cand;
            cand = (32'(rr_q) + i) % NrMasters;
            if (!win_found && bus.m_req_valid_i[cand[IdW-1:0]]) begin
                win_found = 1'b1;
                win       = cand[IdW-1:0];
            end
        end
    end

    // Decode the winning address against the half-open regions of the SoC map
    always_comb begin
        win_addr = 64'(bus.m_req_addr_i[win]);
        dec_hit  = 1'b1;
        dec_idx  = '0;
        if (win_addr < 64'h0000_1000) begin
            dec_idx = IdxW'(3);
        end else if (win_addr >= 64'h0200_0000 && win_addr < 64'h020C_0000) begin
            dec_idx = IdxW'(2);
        end else if (win_addr >= 64'h8000_0000 && win_addr < 64'hA000_0000) begin
            dec_idx = IdxW'(0);
        end else if (win_addr >= 64'hE000_0000 && win_addr < 64'h1_0000_0000) begin
            dec_idx = IdxW'(1);
        end else begin
            dec_hit = 1'b0;
        end
    end

    // The comparison uses >= because an accept on the last cycle leaves WAIT one count later
    assign timeout = (cnt_q >= CntW'(TimeoutCycles - 1));

    // Next-state logic and handshake outputs
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        bus.m_req_ready_o = '0;
        bus.m_rsp_valid_o = '0;
        bus.m_rsp_rdata_o = '0;
        bus.m_rsp_err_o   = 1'b0;
        bus.s_req_valid_o = '0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    bus.m_req_ready_o[win] = 1'b1;
                    id_d    = win;
                    idx_d   = dec_idx;
                    addr_d  = bus.m_req_addr_i[win];
                    we_d    = bus.m_req_we_i[win];
                    wdata_d = bus.m_req_wdata_i[win];
                    rr_d    = (32'(win) == NrMasters - 1) ? '0 : win + IdW'(1);
                    if (dec_hit) begin
                        cnt_d   = '0;
                        state_d = StIssue;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                bus.s_req_valid_o[idx_q] = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (bus.s_req_ready_i[idx_q]) begin
                    state_d = StWait;
                end else if (timeout) begin
                    // Recovery path: valid is withdrawn without a handshake
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (bus.s_rsp_valid_i[idx_q]) begin
                    rdata_d = bus.s_rsp_rdata_i[idx_q];
                    err_d   = bus.s_rsp_err_i[idx_q];
                    state_d = StResp;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                bus.m_rsp_valid_o[id_q] = 1'b1;
                bus.m_rsp_rdata_o       = rdata_q;
                bus.m_rsp_err_o         = err_q;
                if (bus.m_rsp_ready_i[id_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.s_req_addr_o  = addr_q;
    assign bus.s_req_we_o    = we_q;
    assign bus.s_req_wdata_o = wdata_q;

    // State and latched transaction registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rr_q    <= '0;
            id_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Self-checking bench for soc_periph_arbiter. It covers directed cases and randomized
// transactions, checked against a transaction-level reference model.
module tb_soc_periph_arbiter;

    localparam int NM = 2;
    localparam int NT = 4;
    localparam int TO = 16;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NEVER = 99;

    // Address map as a table: base, length, target index
    localparam logic [63:0] RBASE [4] = '{64'h0, 64'h0200_0000, 64'h8000_0000, 64'hE000_0000};
    localparam logic [63:0] RLEN  [4] = '{64'h1000, 64'h000C_0000, 64'h2000_0000, 64'h2000_0000};
    localparam int          RIDX  [4] = '{3, 2, 0, 1};
    localparam logic [63:0] EDGES [14] = '{
        64'h0, 64'hFFF, 64'h1000, 64'h01FF_FFFF, 64'h0200_0000, 64'h020B_FFFF, 64'h020C_0000,
        64'h7FFF_FFFF, 64'h8000_0000, 64'h9FFF_FFFF, 64'hA000_0000, 64'hDFFF_FFFF,
        64'hFFFF_FFFF, 64'h1_0000_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soc_periph_arbiter_if #(.NrMasters(NM), .NrTargets(NT), .AddrWidth(AW), .DataWidth(DW)) bus ();

    soc_periph_arbiter #(
        .NrMasters    (NM),
        .NrTargets    (NT),
        .TimeoutCycles(TO),
        .AddrWidth    (AW),
        .DataWidth    (DW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rr       = 0;

    logic [AW-1:0] m_addr  [NM];
    logic          m_we    [NM];
    logic [DW-1:0] m_wdata [NM];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int ref_decode(input logic [63:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a >= RBASE[i] && (a - RBASE[i]) < RLEN[i]) return RIDX[i];
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] rand_addr();
        int r;
        case ($urandom_range(0, 5))
            0: rand_addr = EDGES[$urandom_range(0, 13)];
            1: rand_addr = rnd64();
            default: begin
                r = $urandom_range(0, 3);
                rand_addr = RBASE[r] + (rnd64() % RLEN[r]);
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_targets();
        bus.s_req_ready_i = '0;
        bus.s_rsp_valid_i = '0;
        bus.s_rsp_err_i   = '0;
        for (int k = 0; k < NT; k++) bus.s_rsp_rdata_i[k] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_m_req_ready"}, bus.m_req_ready_o, 0);
        check_val({tag, "_m_rsp_valid"}, bus.m_rsp_valid_o, 0);
        check_val({tag, "_m_rsp_rdata"}, bus.m_rsp_rdata_o, 0);
        check_val({tag, "_m_rsp_err"}, bus.m_rsp_err_o, 0);
        check_val({tag, "_s_req_valid"}, bus.s_req_valid_o, 0);
        check_val({tag, "_s_req_addr"}, bus.s_req_addr_o, 0);
        check_val({tag, "_s_req_we"}, bus.s_req_we_o, 0);
        check_val({tag, "_s_req_wdata"}, bus.s_req_wdata_o, 0);
    endtask

    // One complete transaction. Call it in an IDLE cycle, between a negedge and the next posedge.
    // acc/rsp are the cycles, counted from the first ISSUE cycle, in which the target accepts
    // and responds. A value of NEVER means the target never does so.
    task automatic run_txn(input logic [NM-1:0] vld, input int acc, input int rsp,
                           input logic [DW-1:0] tdata, input logic terr, input int mdly);
        int w;
        int idx;
        int last;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [NT-1:0] sel;
        w = -1;
        for (int i = 0; i < NM; i++) begin
            int c;
            c = (rr + i) % NM;
            if (w < 0 && vld[c]) w = c;
        end
        for (int i = 0; i < NM; i++) begin
            bus.m_req_addr_i[i]  = m_addr[i];
            bus.m_req_we_i[i]    = m_we[i];
            bus.m_req_wdata_i[i] = m_wdata[i];
        end
        bus.m_req_valid_i = vld;
        #1;
        check_val("grant", bus.m_req_ready_o, 64'(1) << w);
        check_val("idle_s_req_valid", bus.s_req_valid_o, 0);
        check_val("idle_m_rsp_valid", bus.m_rsp_valid_o, 0);
        rr  = (w + 1) % NM;
        idx = ref_decode(m_addr[w]);
        step();
        bus.m_req_valid_i[w] = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b1;
        if (idx >= 0) begin
            sel  = NT'(1) << idx;
            last = TO - 1;
            if (acc < TO && rsp < TO) begin
                last      = rsp;
                exp_rdata = tdata;
                exp_err   = terr;
            end
            for (int t = 0; t <= last; t++) begin
                logic [NT-1:0] nz_rdy;
                logic [NT-1:0] nz_vld;
                nz_rdy = NT'($urandom()) & ~sel;
                nz_vld = NT'($urandom()) & ~sel;
                bus.s_req_ready_i = ((t >= acc) ? sel : '0) | nz_rdy;
                bus.s_rsp_valid_i = ((t == rsp) ? sel : '0) | nz_vld;
                for (int k = 0; k < NT; k++) begin
                    bus.s_rsp_rdata_i[k] = (k == idx) ? tdata : rnd64();
                    bus.s_rsp_err_i[k]   = (k == idx) ? terr : 1'($urandom());
                end
                #1;
                check_val("s_req_valid", bus.s_req_valid_o, (t <= acc) ? 64'(sel) : 64'(0));
                if (t <= acc) begin
                    check_val("s_req_addr", bus.s_req_addr_o, m_addr[w]);
                    check_val("s_req_we", bus.s_req_we_o, m_we[w]);
                    check_val("s_req_wdata", bus.s_req_wdata_o, m_wdata[w]);
                end
                check_val("busy_m_rsp_valid", bus.m_rsp_valid_o, 0);
                check_val("busy_m_req_ready", bus.m_req_ready_o, 0);
                step();
            end
        end
        clear_targets();
        for (int k = 0; k <= mdly; k++) begin
            if (k == mdly) begin
                bus.m_rsp_ready_i[w] = 1'b1;
                bus.m_req_valid_i    = '0;
            end
            #1;
            check_val("m_rsp_valid", bus.m_rsp_valid_o, 64'(1) << w);
            check_val("m_rsp_rdata", bus.m_rsp_rdata_o, exp_rdata);
            check_val("m_rsp_err", bus.m_rsp_err_o, exp_err);
            check_val("resp_s_req_valid", bus.s_req_valid_o, 0);
            check_val("resp_m_req_ready", bus.m_req_ready_o, 0);
            step();
        end
        bus.m_rsp_ready_i = '0;
        #1;
        check_val("after_m_rsp_valid", bus.m_rsp_valid_o, 0);
        check_val("after_m_rsp_rdata", bus.m_rsp_rdata_o, 0);
        check_val("after_m_rsp_err", bus.m_rsp_err_o, 0);
    endtask

    // A stray target response while IDLE must not reach any master
    task automatic late_rsp(input int idx);
        bus.s_rsp_valid_i[idx] = 1'b1;
        bus.s_rsp_rdata_i[idx] = rnd64();
        #1;
        check_val("late_m_rsp_valid_now", bus.m_rsp_valid_o, 0);
        step();
        clear_targets();
        #1;
        check_val("late_m_rsp_valid", bus.m_rsp_valid_o, 0);
        check_val("late_m_rsp_err", bus.m_rsp_err_o, 0);
        check_val("late_s_req_valid", bus.s_req_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int rsp;
        bus.m_req_valid_i = '0;
        bus.m_rsp_ready_i = '0;
        for (int i = 0; i < NM; i++) begin
            bus.m_req_addr_i[i]  = '0;
            bus.m_req_we_i[i]    = 1'b0;
            bus.m_req_wdata_i[i] = '0;
            m_addr[i]  = '0;
            m_we[i]    = 1'b0;
            m_wdata[i] = '0;
        end
        clear_targets();
        rst = 1'b1;
        step();
        step();
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        rr  = 0;

        // Basic read: DRAM accepts at once and responds the next cycle
        m_addr[0] = 64'h8000_0010;
        m_we[0]   = 1'b0;
        m_wdata[0] = rnd64();
        run_txn(2'b01, 0, 1, 64'hDEAD_BEEF, 1'b0, 0);

        // Fairness: both masters request every time
        for (int n = 0; n < 4; n++) begin
            m_addr[0] = 64'h8000_0100 + 64'(n);
            m_addr[1] = 64'hE000_0200 + 64'(n);
            m_we[0] = 1'b1;
            m_we[1] = 1'b0;
            m_wdata[0] = rnd64();
            m_wdata[1] = rnd64();
            run_txn(2'b11, 1, 2, rnd64(), 1'b0, n % 2);
        end

        // Unmapped request from M1
        m_addr[1] = 64'h1000_0000;
        run_txn(2'b10, 0, 1, rnd64(), 1'b0, 1);

        // Decode boundaries
        for (int i = 0; i < 14; i++) begin
            m_addr[1]  = EDGES[i];
            m_we[1]    = 1'(i);
            m_wdata[1] = rnd64();
            run_txn(2'b10, 0, 1, rnd64(), 1'b0, 0);
        end

        // Timeout after accept, then a late CLINT response in IDLE
        m_addr[0] = 64'h0200_0000;
        run_txn(2'b01, 0, NEVER, rnd64(), 1'b0, 1);
        late_rsp(2);
        // Timeout with no accept at all
        m_addr[0] = 64'h0200_0040;
        run_txn(2'b01, NEVER, NEVER, rnd64(), 1'b0, 0);
        // A response in the last cycle before the timeout still wins
        m_addr[1] = 64'h0000_0800;
        run_txn(2'b10, 4, TO - 1, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);

        // Reset in WAIT: grant, accept, wait one cycle, then reset
        m_addr[0] = 64'h0200_0000;
        bus.m_req_addr_i[0] = m_addr[0];
        bus.m_req_valid_i   = 2'b01;
        #1;
        check_val("rst_grant", bus.m_req_ready_o, 2'b01);
        step();
        bus.m_req_valid_i    = '0;
        bus.s_req_ready_i[2] = 1'b1;
        #1;
        check_val("rst_issue", bus.s_req_valid_o, 4'b0100);
        step();
        bus.s_req_ready_i = '0;
        #1;
        check_val("rst_wait", bus.s_req_valid_o, 0);
        rst = 1'b1;
        step();
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        rr  = 0;
        late_rsp(2);
        m_addr[0] = 64'h9000_0000;
        m_addr[1] = 64'h9000_0008;
        run_txn(2'b11, 0, 1, rnd64(), 1'b0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NM; i++) begin
                m_addr[i]  = rand_addr();
                m_we[i]    = 1'($urandom());
                m_wdata[i] = rnd64();
            end
            acc = $urandom_range(0, 3);
            rsp = acc + $urandom_range(1, 3);
            case ($urandom_range(0, 9))
                0: acc = NEVER;
                1: rsp = NEVER;
                2: begin
                    acc = $urandom_range(0, TO - 3);
                    rsp = TO - 1;
                end
                default: ;
            endcase
            run_txn(NM'($urandom_range(1, 3)), acc, rsp, rnd64(), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
